// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and FSM encoding for the SRAM frame-buffer arbiter.
package fb_pkg;
   localparam int PIX_W_DEF = 5;
   localparam logic [4:0] TRANSPARENT_KEY = 5'h15;
   localparam logic [4:0] BG_COLOR = 5'h11;
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
endpackage

// File: rtl/sram_frame_arbiter_if.sv
// sram_frame_arbiter_if: scan-out, draw-engine, swap control and SRAM pins of the arbiter.
interface sram_frame_arbiter_if import fb_pkg::*; #(
   parameter int ADDR_W = 18,
   parameter int PIX_W  = PIX_W_DEF
) ();
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;
   logic              rd_valid;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_pixel;
   logic              wr_ready;
   logic              swap_req;
   logic              frame_sync;
   logic              buf_sel;
   logic              swap_done;
   logic [ADDR_W:0]   sram_addr;
   logic              sram_we_n;
   logic              sram_oe_n;
   logic [PIX_W-1:0]  sram_wdata;
   logic [PIX_W-1:0]  sram_rdata;
   modport master (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_pixel, swap_req, frame_sync, sram_rdata,
      input  rd_data, rd_valid, wr_ready, buf_sel, swap_done, sram_addr, sram_we_n, sram_oe_n, sram_wdata
   );
   modport slave (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_pixel, swap_req, frame_sync, sram_rdata,
      output rd_data, rd_valid, wr_ready, buf_sel, swap_done, sram_addr, sram_we_n, sram_oe_n, sram_wdata
   );
endinterface

// File: rtl/fb_write_fifo.sv
// fb_write_fifo: power-of-2 write queue; a push while full is taken only alongside a pop.
module fb_write_fifo #(
   parameter int W     = 23,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];
   always_ff @(posedge Clk)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge Clk)
      if (Reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: double-buffered SRAM arbiter, reads over queued writes, vsync-aligned swap.
// Define FB_TRANSPARENT_DROP_EN to silently discard writes of the transparent colour key.
module sram_frame_arbiter import fb_pkg::*; #(
   parameter int ADDR_W      = 18,
   parameter int PIX_W       = PIX_W_DEF,
   parameter int WFIFO_DEPTH = 4
) (
   input logic Clk,
   input logic Reset,
   sram_frame_arbiter_if.slave bus
);
   localparam int CW = $clog2(WFIFO_DEPTH) + 1;
   state_t              state, state_nx;
   logic [ADDR_W:0]     acc_addr;
   logic [PIX_W-1:0]    acc_data, rd_data;
   logic [ADDR_W+PIX_W-1:0] head;
   logic [CW-1:0]       count;
   logic                rd_valid, buf_sel, swap_pending, swap_done;
   logic                push, pop, full, empty, fire;
   fb_write_fifo #(.W(ADDR_W + PIX_W), .DEPTH(WFIFO_DEPTH), .CW(CW)) u_fifo (
      .Clk(Clk), .Reset(Reset), .push(push), .din({bus.wr_addr, bus.wr_pixel}), .pop(pop),
      .dout(head), .full(full), .empty(empty), .count(count)
   );
   assign bus.wr_ready  = !full;
   assign bus.rd_data   = rd_data;
   assign bus.rd_valid  = rd_valid;
   assign bus.buf_sel   = buf_sel;
   assign bus.swap_done = swap_done;
`ifdef FB_TRANSPARENT_DROP_EN
   assign push = bus.wr_valid && !full && bus.wr_pixel != PIX_W'(TRANSPARENT_KEY);
`else
   assign push = bus.wr_valid && !full;
`endif
   assign pop  = state_nx == WRITE;
   // An in-flight write still belongs to the back buffer, so it blocks the swap.
   assign fire = bus.frame_sync && swap_pending && count == '0 && state != WRITE;
   always_ff @(posedge Clk)
      if (Reset) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = bus.rd_req ? READ : !empty ? WRITE : IDLE;
   always_comb begin
      bus.sram_addr  = state == IDLE ? '0 : acc_addr;
      bus.sram_oe_n  = state != READ;
      bus.sram_we_n  = state != WRITE;
      bus.sram_wdata = state == WRITE ? acc_data : '0;
   end
   // Buffer bit is captured with the access so a swap cannot retarget it mid-cycle.
   always_ff @(posedge Clk)
      if (Reset) begin
         acc_addr     <= '0;
         acc_data     <= '0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         buf_sel      <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         acc_addr     <= bus.rd_req ? {buf_sel, bus.rd_addr} : {~buf_sel, head[ADDR_W+PIX_W-1:PIX_W]};
         acc_data     <= head[PIX_W-1:0];
         rd_valid     <= state == READ;
         if (state == READ) rd_data <= bus.sram_rdata;
         buf_sel      <= buf_sel ^ fire;
         swap_done    <= fire;
         swap_pending <= !fire && (swap_pending || bus.swap_req);
      end
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// tb_sram_frame_arbiter: directed stimulus with queued expectations checked by a negedge monitor.
module tb_sram_frame_arbiter;
   localparam logic [31:0] NONE = 32'hFFFF_FFFF;
   logic Clk = 1'b0;
   logic Reset;
   logic mon_en = 1'b0;
   int checks = 0, failures = 0;
   logic [18:0] rdq [$];
   logic [4:0]  rvq [$];
   logic [23:0] wq [$];
   logic        sq [$];
   always #5 Clk = ~Clk;
   sram_frame_arbiter_if #(.ADDR_W(18), .PIX_W(5)) bus ();
   sram_frame_arbiter #(.ADDR_W(18), .PIX_W(5), .WFIFO_DEPTH(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask
   task automatic check_reset();
      chk("rst_buf_sel", 32'(bus.buf_sel), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_swap_done", 32'(bus.swap_done), 0);
      chk("rst_we_n", 32'(bus.sram_we_n), 1);
      chk("rst_oe_n", 32'(bus.sram_oe_n), 1);
      chk("rst_sram_addr", 32'(bus.sram_addr), 0);
      chk("rst_sram_wdata", 32'(bus.sram_wdata), 0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 1);
   endtask
   always @(negedge Clk)
      if (mon_en) begin
         if (!bus.sram_oe_n) chk("rd_addr", 32'(bus.sram_addr), rdq.size() != 0 ? 32'(rdq.pop_front()) : NONE);
         if (!bus.sram_we_n) chk("write", 32'({bus.sram_addr, bus.sram_wdata}), wq.size() != 0 ? 32'(wq.pop_front()) : NONE);
         if (bus.rd_valid) chk("rd_data", 32'(bus.rd_data), rvq.size() != 0 ? 32'(rvq.pop_front()) : NONE);
         if (bus.swap_done) chk("swap_buf_sel", 32'(bus.buf_sel), sq.size() != 0 ? 32'(sq.pop_front()) : NONE);
      end
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
   initial begin
      Reset = 1'b1;
      bus.rd_req = 0; bus.rd_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_pixel = '0;
      bus.swap_req = 0; bus.frame_sync = 0; bus.sram_rdata = '0;
      repeat (3) cyc();
      check_reset();
      Reset = 1'b0;
      mon_en = 1'b1;
      // single read, 2-cycle latency
      bus.rd_req = 1; bus.rd_addr = 18'h00010; bus.sram_rdata = 5'h0A;
      rdq.push_back(19'h00010); rvq.push_back(5'h0A);
      cyc();
      bus.rd_req = 0;
      repeat (3) cyc();
      // fill the queue while reads hold the bus, then drain to the back buffer
      bus.rd_req = 1; bus.rd_addr = 18'h00020; bus.sram_rdata = 5'h07;
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1; bus.wr_addr = 18'(i); bus.wr_pixel = 5'h03;
         rdq.push_back(19'h00020); rvq.push_back(5'h07);
         cyc();
      end
      bus.wr_valid = 0;
      chk("wr_ready_full", 32'(bus.wr_ready), 0);
      rdq.push_back(19'h00020); rvq.push_back(5'h07);
      cyc();
      chk("wr_ready_still_full", 32'(bus.wr_ready), 0);
      bus.rd_req = 0;
      for (int i = 0; i < 4; i++) wq.push_back({19'h40000 + 19'(i), 5'h03});
      repeat (6) cyc();
      chk("wr_ready_drained", 32'(bus.wr_ready), 1);
      // swap with empty queue
      bus.swap_req = 1;
      cyc();
      bus.swap_req = 0; bus.frame_sync = 1; sq.push_back(1'b1);
      cyc();
      bus.frame_sync = 0;
      chk("buf_sel_after_swap", 32'(bus.buf_sel), 1);
      bus.wr_valid = 1; bus.wr_addr = 18'h5; bus.wr_pixel = 5'h04;
      wq.push_back({19'h00005, 5'h04});
      cyc();
      bus.wr_valid = 0;
      repeat (3) cyc();
      // swap deferred while writes are queued; repeated swap_req absorbed
      bus.rd_req = 1; bus.rd_addr = 18'h00030; bus.sram_rdata = 5'h12;
      bus.swap_req = 1;
      for (int i = 0; i < 2; i++) begin
         bus.wr_valid = 1; bus.wr_addr = 18'(8 + i); bus.wr_pixel = 5'h09;
         rdq.push_back(19'h40030); rvq.push_back(5'h12);
         cyc();
      end
      bus.wr_valid = 0; bus.swap_req = 0; bus.frame_sync = 1;
      rdq.push_back(19'h40030); rvq.push_back(5'h12);
      cyc();
      bus.frame_sync = 0; bus.rd_req = 0;
      chk("buf_sel_deferred", 32'(bus.buf_sel), 1);
      wq.push_back({19'h00008, 5'h09}); wq.push_back({19'h00009, 5'h09});
      repeat (4) cyc();
      bus.frame_sync = 1; sq.push_back(1'b0);
      cyc();
      bus.frame_sync = 0;
      cyc();
      chk("buf_sel_second_swap", 32'(bus.buf_sel), 0);
      bus.frame_sync = 1;
      cyc();
      bus.frame_sync = 0;
      cyc();
      chk("buf_sel_no_extra_swap", 32'(bus.buf_sel), 0);
      // transparent colour key
      bus.wr_valid = 1; bus.wr_addr = 18'h5; bus.wr_pixel = 5'h15;
`ifndef FB_TRANSPARENT_DROP_EN
      wq.push_back({19'h40005, 5'h15});
`endif
      cyc();
      bus.wr_valid = 0;
      repeat (3) cyc();
      // reset during a write with more queued behind it
      bus.rd_req = 1; bus.rd_addr = 18'h00040; bus.sram_rdata = 5'h1F;
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1; bus.wr_addr = 18'(16 + i); bus.wr_pixel = 5'h01;
         rdq.push_back(19'h00040); rvq.push_back(5'h1F);
         cyc();
      end
      bus.wr_valid = 0; bus.rd_req = 0;
      wq.push_back({19'h40010, 5'h01});
      cyc();
      chk("in_write_before_reset", 32'(bus.sram_we_n), 0);
      Reset = 1;
      cyc();
      check_reset();
      Reset = 0;
      repeat (5) cyc();
      chk("rdq_left", 32'(rdq.size()), 0);
      chk("rvq_left", 32'(rvq.size()), 0);
      chk("wq_left", 32'(wq.size()), 0);
      chk("sq_left", 32'(sq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
